// File: rtl/zx_pager.sv
// Spectrum memory/IO bus controller: delayed CPU reset, 7FFD/1FFD paging,
// ROM/RAM selects, RAM write strobe, screen-page select and CPU read mux.
module zx_pager #(
  parameter int unsigned RAM_PAGE_BITS = 3,
  parameter int unsigned ROM_PAGE_BITS = 1,
  parameter int unsigned RESET_CYCLES  = 32,
  parameter bit          MODE_128      = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     mreq,
  input  logic                     iorq,
  input  logic                     rd,
  input  logic                     wr,
  input  logic [15:0]              a,
  input  logic [7:0]               cpuDo,
  input  logic [7:0]               memData,
  input  logic [7:0]               ulaData,
  output logic                     cpuReset,
  output logic [7:0]               cpuDi,
  output logic                     romCs,
  output logic                     ramCs,
  output logic                     ramWr,
  output logic [ROM_PAGE_BITS-1:0] romPage,
  output logic [RAM_PAGE_BITS-1:0] ramPage,
  output logic [13:0]              memAddr,
  output logic                     vmmPage,
  output logic                     locked
);

  localparam int unsigned      CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESET_CYCLES - 2);

  logic [CNT_W-1:0]         rst_cnt;
  logic [RAM_PAGE_BITS-1:0] page_q;
  logic [RAM_PAGE_BITS-1:0] page_d;
  logic [ROM_PAGE_BITS-1:0] rom_q;
  logic [ROM_PAGE_BITS-1:0] rom_d;
  logic                     vmm_d;
  logic                     lock_d;
  logic                     p7ffd;
  logic                     p1ffd;
  logic                     p7ffd_q;
  logic                     p1ffd_q;
  logic                     wr7ffd;
  logic                     wr1ffd;

  // Partial decode: 1FFD also satisfies the 7FFD decode, so it writes both.
  assign p7ffd = !iorq && !wr && mreq && !a[15] && !a[1];
  assign p1ffd = !iorq && !wr && mreq && (a[15:12] == 4'b0001) && !a[1];

  // A write fires once, on the first clock the strobe is seen active.
  assign wr7ffd = MODE_128 && !locked && p7ffd && !p7ffd_q;
  assign wr1ffd = MODE_128 && (ROM_PAGE_BITS == 2) && !locked && p1ffd && !p1ffd_q;

  // Next paging state
  always_comb begin
    page_d = page_q;
    vmm_d  = vmmPage;
    rom_d  = rom_q;
    lock_d = locked;
    if (wr7ffd) begin
      page_d   = RAM_PAGE_BITS'({cpuDo[7:6], cpuDo[2:0]});
      vmm_d    = cpuDo[3];
      rom_d[0] = cpuDo[4];
      lock_d   = cpuDo[5];
    end
    if (wr1ffd) begin
      rom_d[ROM_PAGE_BITS-1] = cpuDo[2];
    end
  end

  // Reset stretcher, strobe history and paging registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rst_cnt  <= '0;
      cpuReset <= 1'b0;
      p7ffd_q  <= 1'b0;
      p1ffd_q  <= 1'b0;
      page_q   <= '0;
      rom_q    <= '0;
      vmmPage  <= 1'b0;
      locked   <= 1'b0;
    end else begin
      if (!cpuReset) begin
        rst_cnt  <= rst_cnt + CNT_W'(1);
        cpuReset <= (rst_cnt == CNT_LAST);
      end
      p7ffd_q <= p7ffd;
      p1ffd_q <= p1ffd;
      page_q  <= page_d;
      rom_q   <= rom_d;
      vmmPage <= vmm_d;
      locked  <= lock_d;
    end
  end

  assign romPage = rom_q;
  assign memAddr = a[13:0];

  // Address map, write strobe and read mux
  always_comb begin
    romCs = !mreq && (a[15:14] == 2'b00);
    ramCs = !mreq && (a[15:14] != 2'b00);
    ramWr = !(ramCs && !wr);
    case (a[15:14])
      2'b01:   ramPage = RAM_PAGE_BITS'(5);
      2'b10:   ramPage = RAM_PAGE_BITS'(2);
      2'b11:   ramPage = page_q;
      default: ramPage = '0;
    endcase
    if (!mreq && !rd) begin
      cpuDi = memData;
    end else if (!iorq && !rd && !a[0]) begin
      cpuDi = ulaData;
    end else begin
      cpuDi = 8'hFF;
    end
  end

endmodule

// File: tb/tb_zx_pager.sv
// Bench for zx_pager: three builds on one shared bus, checked against a
// rule-level model every cycle, plus decode vectors and directed sequences.
module tb_zx_pager;

  logic        clock = 1'b0;
  logic        reset;
  logic        mreq, iorq, rd, wr;
  logic [15:0] a;
  logic [7:0]  cpuDo, memData, ulaData;

  logic       d0_cpuReset, d0_romCs, d0_ramCs, d0_ramWr, d0_vmmPage, d0_locked;
  logic [7:0] d0_cpuDi;
  logic [0:0] d0_romPage;
  logic [2:0] d0_ramPage;
  logic [13:0] d0_memAddr;

  logic       d1_cpuReset, d1_romCs, d1_ramCs, d1_ramWr, d1_vmmPage, d1_locked;
  logic [7:0] d1_cpuDi;
  logic [1:0] d1_romPage;
  logic [4:0] d1_ramPage;
  logic [13:0] d1_memAddr;

  logic       d2_cpuReset, d2_romCs, d2_ramCs, d2_ramWr, d2_vmmPage, d2_locked;
  logic [7:0] d2_cpuDi;
  logic [0:0] d2_romPage;
  logic [2:0] d2_ramPage;
  logic [13:0] d2_memAddr;

  zx_pager #(.RAM_PAGE_BITS(3), .ROM_PAGE_BITS(1), .RESET_CYCLES(32), .MODE_128(1'b1)) u_d0 (
    .clock(clock), .reset(reset), .mreq(mreq), .iorq(iorq), .rd(rd), .wr(wr), .a(a),
    .cpuDo(cpuDo), .memData(memData), .ulaData(ulaData), .cpuReset(d0_cpuReset),
    .cpuDi(d0_cpuDi), .romCs(d0_romCs), .ramCs(d0_ramCs), .ramWr(d0_ramWr),
    .romPage(d0_romPage), .ramPage(d0_ramPage), .memAddr(d0_memAddr),
    .vmmPage(d0_vmmPage), .locked(d0_locked));

  zx_pager #(.RAM_PAGE_BITS(5), .ROM_PAGE_BITS(2), .RESET_CYCLES(2), .MODE_128(1'b1)) u_d1 (
    .clock(clock), .reset(reset), .mreq(mreq), .iorq(iorq), .rd(rd), .wr(wr), .a(a),
    .cpuDo(cpuDo), .memData(memData), .ulaData(ulaData), .cpuReset(d1_cpuReset),
    .cpuDi(d1_cpuDi), .romCs(d1_romCs), .ramCs(d1_ramCs), .ramWr(d1_ramWr),
    .romPage(d1_romPage), .ramPage(d1_ramPage), .memAddr(d1_memAddr),
    .vmmPage(d1_vmmPage), .locked(d1_locked));

  zx_pager #(.RAM_PAGE_BITS(3), .ROM_PAGE_BITS(1), .RESET_CYCLES(32), .MODE_128(1'b0)) u_d2 (
    .clock(clock), .reset(reset), .mreq(mreq), .iorq(iorq), .rd(rd), .wr(wr), .a(a),
    .cpuDo(cpuDo), .memData(memData), .ulaData(ulaData), .cpuReset(d2_cpuReset),
    .cpuDi(d2_cpuDi), .romCs(d2_romCs), .ramCs(d2_ramCs), .ramWr(d2_ramWr),
    .romPage(d2_romPage), .ramPage(d2_ramPage), .memAddr(d2_memAddr),
    .vmmPage(d2_vmmPage), .locked(d2_locked));

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // Build parameters of each instance
  function automatic int ram_bits(input int i); return (i == 1) ? 5 : 3; endfunction
  function automatic int rom_bits(input int i); return (i == 1) ? 2 : 1; endfunction
  function automatic int rst_cyc(input int i);  return (i == 1) ? 2 : 32; endfunction
  function automatic bit paging(input int i);   return i != 2; endfunction

  // Reference model: state per instance, from the port rules
  int m_page[3], m_vmm[3], m_rom[3], m_lock[3];
  int m_cyc;
  bit prev7, prev1;

  function automatic bit s7();
    return !iorq && !wr && mreq && !a[15] && !a[1];
  endfunction
  function automatic bit s1();
    return !iorq && !wr && mreq && (a >= 16'h1000) && (a < 16'h2000) && !a[1];
  endfunction

  function automatic int rom_next(input int i);
    int r;
    r = m_rom[i];
    if (s7() && !prev7) r = (r / 2) * 2 + int'(cpuDo[4]);
    if (s1() && !prev1 && rom_bits(i) == 2) r = (r % 2) + 2 * int'(cpuDo[2]);
    return r;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_cyc <= 0;
      prev7 <= 1'b0;
      prev1 <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        m_page[i] <= 0; m_vmm[i] <= 0; m_rom[i] <= 0; m_lock[i] <= 0;
      end
    end else begin
      if (m_cyc < 1000) m_cyc <= m_cyc + 1;
      prev7 <= s7();
      prev1 <= s1();
      for (int i = 0; i < 3; i++) begin
        if (paging(i) && m_lock[i] == 0) begin
          if (s7() && !prev7) begin
            m_page[i] <= (int'(cpuDo[7:6]) * 8 + int'(cpuDo[2:0])) % (1 << ram_bits(i));
            m_vmm[i]  <= int'(cpuDo[3]);
            m_lock[i] <= int'(cpuDo[5]);
          end
          m_rom[i] <= rom_next(i);
        end
      end
    end
  end

  typedef struct {
    int crst, vmm, lock, rom, romcs, ramcs, ramwr, rpage, maddr, di;
  } obs_t;

  task automatic get_obs(input int i, output obs_t o);
    case (i)
      0: o = '{int'(d0_cpuReset), int'(d0_vmmPage), int'(d0_locked), int'(d0_romPage),
               int'(d0_romCs), int'(d0_ramCs), int'(d0_ramWr), int'(d0_ramPage),
               int'(d0_memAddr), int'(d0_cpuDi)};
      1: o = '{int'(d1_cpuReset), int'(d1_vmmPage), int'(d1_locked), int'(d1_romPage),
               int'(d1_romCs), int'(d1_ramCs), int'(d1_ramWr), int'(d1_ramPage),
               int'(d1_memAddr), int'(d1_cpuDi)};
      default: o = '{int'(d2_cpuReset), int'(d2_vmmPage), int'(d2_locked), int'(d2_romPage),
               int'(d2_romCs), int'(d2_ramCs), int'(d2_ramWr), int'(d2_ramPage),
               int'(d2_memAddr), int'(d2_cpuDi)};
    endcase
  endtask

  // Compare every output of every instance against the model
  task automatic check_all();
    obs_t o;
    int   romcs, ramcs, di, rp;
    romcs = (!mreq && a < 16'h4000) ? 1 : 0;
    ramcs = (!mreq && a >= 16'h4000) ? 1 : 0;
    if (!mreq && !rd)                di = int'(memData);
    else if (!iorq && !rd && !a[0])  di = int'(ulaData);
    else                             di = 255;
    for (int i = 0; i < 3; i++) begin
      get_obs(i, o);
      rp = (a < 16'h8000) ? 5 : (a < 16'hC000) ? 2 : m_page[i];
      check($sformatf("i%0d_cpuReset", i), o.crst, (m_cyc >= rst_cyc(i) - 1) ? 1 : 0);
      check($sformatf("i%0d_vmmPage", i), o.vmm, m_vmm[i]);
      check($sformatf("i%0d_locked", i), o.lock, m_lock[i]);
      check($sformatf("i%0d_romPage", i), o.rom, m_rom[i]);
      check($sformatf("i%0d_romCs", i), o.romcs, romcs);
      check($sformatf("i%0d_ramCs", i), o.ramcs, ramcs);
      check($sformatf("i%0d_ramWr", i), o.ramwr, (ramcs == 1 && !wr) ? 0 : 1);
      check($sformatf("i%0d_memAddr", i), o.maddr, int'(a) % 16384);
      check($sformatf("i%0d_cpuDi", i), o.di, di);
      if (ramcs == 1) check($sformatf("i%0d_ramPage", i), o.rpage, rp);
    end
  endtask

  task automatic drive(input bit mq, input bit iq, input bit r, input bit w,
                       input logic [15:0] ad, input logic [7:0] d);
    mreq = mq; iorq = iq; rd = r; wr = w; a = ad; cpuDo = d;
  endtask

  task automatic idle();
    drive(1, 1, 1, 1, 16'h0000, 8'h00);
  endtask

  // One clock: inputs were set at a negedge; sample 1 time unit after posedge
  task automatic cycle();
    @(posedge clock);
    #1;
    check_all();
    @(negedge clock);
  endtask

  task automatic out_port(input logic [15:0] ad, input logic [7:0] d);
    drive(1, 0, 1, 0, ad, d);
    cycle();
    idle();
    cycle();
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    check_all();
    @(negedge clock);
    reset = 1'b1;
  endtask

  typedef struct {
    bit          mq, iq, r, w;
    logic [15:0] ad;
    int          e_romcs, e_ramcs, e_ramwr, e_page, e_di;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1, 1, 1, 1, 16'h0000, 0, 0, 1, -1, 255};   // idle bus
    tbl[1] = '{0, 1, 0, 1, 16'h0000, 1, 0, 1, -1, 90};    // ROM read
    tbl[2] = '{0, 1, 1, 0, 16'h1234, 1, 0, 1, -1, 255};   // ROM write: no strobe
    tbl[3] = '{0, 1, 1, 0, 16'h8000, 0, 1, 0, 2, 255};    // RAM write
    tbl[4] = '{0, 1, 0, 1, 16'h4000, 0, 1, 1, 5, 90};     // screen page read
    tbl[5] = '{1, 0, 0, 1, 16'h00FE, 0, 0, 1, -1, 191};   // IN FE
    tbl[6] = '{1, 0, 0, 1, 16'h7FFD, 0, 0, 1, -1, 255};   // 7FFD is write-only
    tbl[7] = '{1, 1, 1, 0, 16'h8000, 0, 0, 1, -1, 255};   // wr without mreq
    tbl[8] = '{0, 1, 0, 1, 16'hFFFF, 0, 1, 1, 0, 90};     // C000 after reset

    reset = 1'b0;
    memData = 8'h5A;
    ulaData = 8'hBF;
    idle();

    // Reset held, then count-out
    repeat (5) @(negedge clock);
    #1;
    check("rst_d0_cpuReset", int'(d0_cpuReset), 0);
    check_all();
    @(negedge clock);
    reset = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      #1;
      check("count_d0_cpuReset", int'(d0_cpuReset), (k >= 31) ? 1 : 0);
      check("count_d1_cpuReset", int'(d1_cpuReset), 1);
      check_all();
      @(negedge clock);
    end

    // Reset reasserted mid-count restarts the count
    pulse_reset();
    repeat (10) cycle();
    reset = 1'b0;
    #1;
    check("midrst_cpuReset", int'(d0_cpuReset), 0);
    @(negedge clock);
    reset = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clock);
      #1;
      check("recount_d0_cpuReset", int'(d0_cpuReset), (k >= 31) ? 1 : 0);
      check_all();
      @(negedge clock);
    end

    // Decode and read-mux vectors
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].mq, tbl[i].iq, tbl[i].r, tbl[i].w, tbl[i].ad, 8'h00);
      #1;
      check($sformatf("vec%0d_romCs", i), int'(d0_romCs), tbl[i].e_romcs);
      check($sformatf("vec%0d_ramCs", i), int'(d0_ramCs), tbl[i].e_ramcs);
      check($sformatf("vec%0d_ramWr", i), int'(d0_ramWr), tbl[i].e_ramwr);
      check($sformatf("vec%0d_cpuDi", i), int'(d0_cpuDi), tbl[i].e_di);
      if (tbl[i].e_page >= 0) check($sformatf("vec%0d_ramPage", i), int'(d0_ramPage), tbl[i].e_page);
      @(negedge clock);
    end
    idle();
    cycle();

    // OUT 7FFD,07 then reads across the map
    out_port(16'h7FFD, 8'h07);
    drive(0, 1, 0, 1, 16'hC000, 8'h00);
    cycle();
    check("p7_ramPage_c000", int'(d0_ramPage), 7);
    check("p7_romCs_c000", int'(d0_romCs), 0);
    check("p7_mode0_ramPage", int'(d2_ramPage), 0);
    drive(0, 1, 0, 1, 16'h4000, 8'h00);
    cycle();
    check("p7_ramPage_4000", int'(d0_ramPage), 5);
    drive(0, 1, 0, 1, 16'h0000, 8'h00);
    cycle();
    check("p7_romCs_0000", int'(d0_romCs), 1);
    check("p7_romPage", int'(d0_romPage), 0);

    // Lock, ignored write, then reset clears
    out_port(16'h7FFD, 8'h38);
    check("lk_vmmPage", int'(d0_vmmPage), 1);
    check("lk_romPage", int'(d0_romPage), 1);
    check("lk_locked", int'(d0_locked), 1);
    out_port(16'h7FFD, 8'h00);
    check("lk_hold_vmmPage", int'(d0_vmmPage), 1);
    check("lk_hold_locked", int'(d0_locked), 1);
    drive(0, 1, 0, 1, 16'hC000, 8'h00);
    cycle();
    check("lk_hold_ramPage", int'(d0_ramPage), 0);
    pulse_reset();
    check("lk_rst_locked", int'(d0_locked), 0);
    check("lk_rst_vmmPage", int'(d0_vmmPage), 0);
    idle();
    cycle();

    // Held strobe with changing data writes once
    drive(1, 0, 1, 0, 16'h7FFD, 8'h01);
    repeat (3) cycle();
    cpuDo = 8'h02;
    repeat (3) cycle();
    idle();
    cycle();
    drive(0, 1, 0, 1, 16'hC000, 8'h00);
    cycle();
    check("hold_ramPage", int'(d0_ramPage), 1);

    // Wide build: 5-bit page and 1FFD ROM bit
    pulse_reset();
    idle();
    cycle();
    out_port(16'h7FFD, 8'hC3);
    drive(0, 1, 0, 1, 16'hC000, 8'h00);
    cycle();
    check("wide_ramPage", int'(d1_ramPage), 27);
    check("narrow_ramPage", int'(d0_ramPage), 3);
    check("mode0_ramPage", int'(d2_ramPage), 0);
    out_port(16'h1FFD, 8'h04);
    check("wide_romPage", int'(d1_romPage), 2);
    check("mode0_romPage", int'(d2_romPage), 0);

    // Randomised traffic against the model
    for (int n = 0; n < 1500; n++) begin
      logic [7:0]  d;
      logic [15:0] ad;
      int          op;
      memData = 8'($urandom);
      ulaData = 8'($urandom);
      d  = 8'($urandom);
      if ($urandom_range(0, 7) != 0) d[5] = 1'b0;
      ad = 16'($urandom);
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 79) == 0) reset = 1'b0;
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2: drive(0, 1, 0, 1, ad, d);
        3, 4:    drive(0, 1, 1, 0, ad, d);
        5:       drive(1, 0, 1, 0, ad & 16'h7FFD, d);
        6:       drive(1, 0, 1, 0, {4'b0001, ad[11:2], 1'b0, ad[0]}, d);
        7:       drive(1, 0, 0, 1, ad, d);
        8:       cpuDo = d;
        default: drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), ad, d);
      endcase
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
